// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word-organised data RAM controller with programmable access latency
// Accepts one request per rising edge of MemRead|MemWrite while idle; reports done/err/busy.
module data_mem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'h10010000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  output logic [31:0] dReadData,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int         IW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          req, req_q, accept;
  logic [29:0]   word_off;
  logic          in_range, illegal;
  logic          wr_q, ill_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   wdata_q, rdata_q;
  logic          done_q, err_q;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req      = MemRead | MemWrite;
  assign accept   = (state_q == S_IDLE) && req && !req_q;
  // Word offset from the base; anything with bits above the index width set is out of range.
  assign word_off = dAddress[31:2] - ADDR_BASE[31:2];
  assign in_range = (dAddress >= ADDR_BASE) && ((word_off >> IW) == '0);
  assign illegal  = (MemRead & MemWrite) | (dAddress[1:0] != 2'b00) | ~in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req;
      done_q  <= (state_q == S_DONE);
      if (accept) begin
        wr_q    <= ~MemRead;
        ill_q   <= illegal;
        idx_q   <= word_off[IW-1:0];
        wdata_q <= dWriteData;
        err_q   <= 1'b0;
      end
      if (state_q == S_ACCESS) begin
        err_q <= ill_q;
        if (!wr_q) rdata_q <= ill_q ? '0 : mem[idx_q];
      end
    end
  end

  // RAM is deliberately not reset; reset only keeps the FSM out of ACCESS.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && wr_q && !ill_q) mem[idx_q] <= wdata_q;
  end

  assign dReadData = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized and directed bench for data_mem_ctrl at LATENCY 2 and 0
module tb_data_mem_ctrl;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] dAddress = '0, dWriteData = '0;
  logic [1:0]  busy_w, done_w, err_w;
  logic [31:0] rdata_w [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData),
    .dReadData(rdata_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  data_mem_ctrl #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData),
    .dReadData(rdata_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int dcnt [2];

  // Reference model: each instance completes a request LATENCY+2 edges after it was accepted.
  bit          pend     [2];
  int          n_acc    [2];
  bit          m_wr     [2];
  bit          m_ill    [2];
  int          m_idx    [2];
  logic [31:0] m_wd     [2];
  logic [31:0] exp_rd   [2];
  bit          exp_err  [2];
  bit          exp_done [2];
  bit          exp_busy [2];
  bit          rq;
  logic [31:0] m_ram    [2][DEPTH];
  logic [31:0] init_val [20];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit req, idle, ill;
    longint off;
    cyc++;
    req = MemRead | MemWrite;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0; exp_rd[k] = '0; exp_err[k] = 0; exp_done[k] = 0; exp_busy[k] = 0;
      end
      rq = 0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      idle = !pend[k];
      exp_done[k] = 0;
      if (pend[k] && cyc == n_acc[k] + lat_of(k) + 2) begin
        if (!m_ill[k]) begin
          if (m_wr[k]) m_ram[k][m_idx[k]] = m_wd[k];
          else         exp_rd[k] = m_ram[k][m_idx[k]];
        end else if (!m_wr[k]) begin
          exp_rd[k] = '0;
        end
        exp_err[k]  = m_ill[k];
        pend[k]     = 0;
        exp_done[k] = 1;
      end
      if (idle && req && !rq) begin
        off = longint'(dAddress) - longint'(BASE);
        ill = (MemRead && MemWrite) || (dAddress[1:0] != 2'b00) || off < 0 || off >= 4 * DEPTH;
        pend[k]  = 1;
        n_acc[k] = cyc;
        m_wr[k]  = !MemRead;
        m_ill[k] = ill;
        m_idx[k] = ill ? 0 : int'(off / 4);
        m_wd[k]  = dWriteData;
        exp_err[k] = 0;
      end
      exp_busy[k] = pend[k] || exp_done[k];
    end
    rq = req;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dcnt[k] += int'(done_w[k]);
      check_eq($sformatf("busy%0d@%0d", k, cyc), 32'(busy_w[k]), 32'(exp_busy[k]));
      check_eq($sformatf("done%0d@%0d", k, cyc), 32'(done_w[k]), 32'(exp_done[k]));
      if (!exp_busy[k] || exp_done[k]) begin
        check_eq($sformatf("err%0d@%0d", k, cyc), 32'(err_w[k]), 32'(exp_err[k]));
        check_eq($sformatf("rdata%0d@%0d", k, cyc), rdata_w[k], exp_rd[k]);
      end
    end
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
    MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d;
    repeat (hold) step();
    MemRead = 0; MemWrite = 0;
    dAddress = $urandom; dWriteData = $urandom;
  endtask

  task automatic settle();
    int t = 0;
    while (busy_w != 2'b00 && t < 40) begin
      step();
      t++;
    end
    check_eq("settle_busy", 32'(busy_w), 32'd0);
    step();
  endtask

  function automatic int pick_word();
    int r = $urandom_range(0, 19);
    return (r < 16) ? r : 1004 + r;
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 9);
    logic [31:0] a;
    case (sel)
      0: a = BASE + 32'(4 * pick_word()) + 32'($urandom_range(1, 3));
      1: case ($urandom_range(0, 3))
           0: a = BASE - 32'd4;
           1: a = BASE + 32'(4 * DEPTH);
           2: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
           default: a = 32'hFFFFFFFC;
         endcase
      default: a = BASE + 32'(4 * pick_word());
    endcase
    return a;
  endfunction

  initial begin
    int w, op;
    for (int k = 0; k < 2; k++) dcnt[k] = 0;
    repeat (3) step();
    rst = 1;
    step();

    // Known contents for every word the random phase may touch.
    for (int i = 0; i < 20; i++) begin
      init_val[i] = $urandom;
      w = (i < 16) ? i : 1004 + i;
      issue(0, 1, BASE + 32'(4 * w), init_val[i], 1);
      settle();
    end

    issue(0, 1, 32'h10010008, 32'hDEADBEEF, 1);
    settle();
    issue(1, 0, 32'h10010008, '0, 1);
    settle();
    for (int k = 0; k < 2; k++) check_eq($sformatf("deadbeef%0d", k), rdata_w[k], 32'hDEADBEEF);

    issue(1, 0, 32'h10010002, '0, 1);
    settle();
    issue(1, 0, BASE + 32'(4 * DEPTH), '0, 1);
    settle();
    issue(0, 1, 32'h0FFFFFFC, 32'h12345678, 1);
    settle();
    issue(1, 1, BASE, 32'hCAFEF00D, 1);
    settle();
    issue(1, 0, BASE, '0, 1);
    settle();
    for (int k = 0; k < 2; k++) check_eq($sformatf("word0_kept%0d", k), rdata_w[k], init_val[0]);

    for (int k = 0; k < 2; k++) dcnt[k] = 0;
    issue(1, 0, BASE + 32'd12, '0, 10);
    settle();
    for (int k = 0; k < 2; k++) check_eq($sformatf("held_one_done%0d", k), 32'(dcnt[k]), 32'd1);

    for (int k = 0; k < 2; k++) dcnt[k] = 0;
    issue(1, 0, BASE + 32'd16, '0, 1);
    step();
    issue(0, 1, BASE + 32'd16, 32'hBAD0BAD0, 1);
    settle();
    for (int k = 0; k < 2; k++) check_eq($sformatf("busy_drop%0d", k), 32'(dcnt[k]), 32'd1);

    for (int k = 0; k < 2; k++) dcnt[k] = 0;
    MemWrite = 1; dAddress = BASE + 32'd20; dWriteData = 32'h5A5A5A5A;
    step();
    MemWrite = 0;
    rst = 0;
    step();
    step();
    rst = 1;
    step();
    step();
    for (int k = 0; k < 2; k++) check_eq($sformatf("rst_no_done%0d", k), 32'(dcnt[k]), 32'd0);
    issue(1, 0, BASE + 32'd20, '0, 1);
    settle();
    for (int k = 0; k < 2; k++) check_eq($sformatf("rst_old_data%0d", k), rdata_w[k], init_val[5]);

    // Random traffic without waiting for idle, so some edges land while busy and are dropped.
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      issue(op >= 4, op < 4 || op == 9, rand_addr(), $urandom, $urandom_range(1, 3));
      repeat ($urandom_range(0, 6)) step();
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
